// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: multi-cycle IDLE/FETCH/DECODE fetch stage with next-PC selection
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        resolve,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero_inv,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired
);
  typedef enum logic [1:0] {IDLE, FETCH, DECODE} state_t;
  state_t state, state_nx;
  logic [31:0] bt, jt, next_pc;
  logic take, ack_hit, advance;
  assign pc_plus4  = pc + 32'd4;
  assign bt        = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  assign jt        = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign take      = branch & (zero ^ zero_inv);
  assign next_pc   = jump ? jt : take ? bt : pc_plus4;
  assign imem_req  = state == FETCH;
  assign imem_addr = pc;
  assign opcode    = instr[31:26];
  assign ack_hit   = state == FETCH && imem_ack;
  assign advance   = state == DECODE && resolve && !stall;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = FETCH;
    if (ack_hit) state_nx = DECODE;
    if (advance) state_nx = FETCH;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      retired     <= '0;
    end else begin
      if (ack_hit) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (advance) begin
        pc          <= next_pc;
        retired     <= retired + 32'd1;
        instr_valid <= 1'b0;
      end
    end
  end
endmodule
